// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Word-addressed RAM that answers the datapath memory interface. The datapath
// raises Read or Write (level) with the MAR address and the MDR write data;
// this block returns read data on MDatain and pulses Done once per access.
//
// Access flow:  IDLE -> BUSY (read latency) -> DONE (Done pulse) -> HOLD
//               IDLE -> DONE (write, committed on the accept edge) -> HOLD
// HOLD waits for both requests to drop, so a request that is held high is
// serviced exactly once.
//
// Optional feature: define MEM_PROTECT_EN to make addresses below PROT_LIMIT
// read-only. A blocked write still completes (Done pulse) but sets Err.
//
// Ports:
//   clk       in   1       system clock, rising edge
//   clr       in   1       asynchronous reset, active-low
//   Read      in   1       read request, level, sampled only in IDLE
//   Write     in   1       write request, level, sampled only in IDLE
//   addr      in   ADDR_W  word address
//   MDataout  in   DATA_W  write data
//   MDatain   out  DATA_W  read data, held between reads
//   Done      out  1       one-cycle completion pulse
//   Err       out  1       sticky error flag, cleared only by clr
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,   // legal 1..15
    parameter int PROT_LIMIT = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] MDataout,
    output logic [DATA_W-1:0] MDatain,
    output logic              Done,
    output logic              Err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = 4;
    // The counter is loaded with RD_LAT-1 so that completion lands exactly
    // RD_LAT edges after the accept edge.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] mdatain_q, mdatain_d;
    logic              err_q,     err_d;

    logic              mem_we;
    logic              wr_blocked;

    logic [DATA_W-1:0] mem [DEPTH];

    // -----------------------------------------------------------------------
    // Write protection
    // -----------------------------------------------------------------------
`ifdef MEM_PROTECT_EN
    // Widened by one bit so a PROT_LIMIT equal to DEPTH still compares right.
    localparam logic [ADDR_W:0] PROT_BOUND =
        (ADDR_W + 1)'((PROT_LIMIT > DEPTH) ? DEPTH : PROT_LIMIT);

    assign wr_blocked = ({1'b0, addr} < PROT_BOUND);
`else
    // Protection compiled out: every address is writable. PROT_LIMIT is a
    // non-negative count, so this term is constant zero.
    assign wr_blocked = (PROT_LIMIT < 0);
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        mdatain_d = mdatain_q;
        err_d     = err_q;
        mem_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Read) begin
                    // Read wins a collision; the write is dropped and flagged.
                    state_d = ST_BUSY;
                    addr_d  = addr;
                    cnt_d   = CNT_LOAD;
                    if (Write) begin
                        err_d = 1'b1;
                    end
                end else if (Write) begin
                    // The RAM write happens on this accept edge, so later
                    // changes of addr/MDataout cannot affect it.
                    state_d = ST_DONE;
                    if (wr_blocked) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end

            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d   = ST_DONE;
                    mdatain_d = mem[addr_q];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                if (!Read && !Write) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control and output registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            mdatain_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            mdatain_q <= mdatain_d;
            err_q     <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // RAM array
    // -----------------------------------------------------------------------
    // NOTE: the storage array has no reset, so it maps onto a RAM macro and a
    // write already committed survives a later clr.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= MDataout;
        end
    end

    assign MDatain = mdatain_q;
    assign Done    = (state_q == ST_DONE);
    assign Err     = err_q;

endmodule
